// File: rtl/splitting_4kb_sequencer.sv
// splitting_4kb_sequencer
//   Splits an upstream INCR burst request into fragments that never cross a
//   2^BOUNDARY_BITS byte boundary (4KB by default). Fragments are issued
//   back to back; the final fragment of each burst carries m_last_o.
//
// Ports
//   ACLK_i, ARESETn_i       clock, asynchronous active-low reset
//   s_addr_i/len/size/id    upstream burst request, s_valid_i/s_ready_o handshake
//   m_addr_o/len/size/id    fragment request, m_valid_o/m_ready_i handshake
//   m_last_o                final fragment of the burst
//   busy_o                  high while fragments are being issued
//
// Optional feature
//   SPLIT_BYPASS_EN  when defined, a non-crossing burst arriving while idle is
//                    forwarded combinationally with zero latency.
module splitting_4kb_sequencer #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int SIZE_WIDTH    = 3,
  parameter int ID_WIDTH      = 4,
  parameter int BOUNDARY_BITS = 12
) (
  input  logic                  ACLK_i,
  input  logic                  ARESETn_i,
  input  logic [ADDR_WIDTH-1:0] s_addr_i,
  input  logic [LEN_WIDTH-1:0]  s_len_i,
  input  logic [SIZE_WIDTH-1:0] s_size_i,
  input  logic [ID_WIDTH-1:0]   s_id_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [LEN_WIDTH-1:0]  m_len_o,
  output logic [SIZE_WIDTH-1:0] m_size_o,
  output logic [ID_WIDTH-1:0]   m_id_o,
  output logic                  m_last_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  busy_o
);

  // Beat counts: BW holds 1..2^LEN_WIDTH, CW also holds 2^BOUNDARY_BITS.
  localparam int BW = LEN_WIDTH + 1;
  localparam int CW = (LEN_WIDTH + 1 > BOUNDARY_BITS + 1) ? LEN_WIDTH + 1 : BOUNDARY_BITS + 1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  last_q, last_d;
  logic [BW-1:0]         remaining_q, remaining_d;
  logic                  ready_en;

  // First-fragment arithmetic on the upstream request.
  logic [BOUNDARY_BITS-1:0] off;
  logic [BOUNDARY_BITS:0]   bnd_span;
  logic [BOUNDARY_BITS:0]   beats_to_bnd;
  logic [CW-1:0]            beats_total;
  logic [CW-1:0]            first_beats;

  // Follow-on fragment arithmetic on the registered fragment.
  logic [BW-1:0]         cur_beats;
  logic [BW-1:0]         rem_after;
  logic [CW-1:0]         frag_max;
  logic [CW-1:0]         next_beats;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic bypass;
  logic accept;
  logic down_hs;

  assign off          = (s_addr_i[BOUNDARY_BITS-1:0] >> s_size_i) << s_size_i;
  assign bnd_span     = {1'b1, {BOUNDARY_BITS{1'b0}}} - {1'b0, off};
  assign beats_to_bnd = bnd_span >> s_size_i;
  assign beats_total  = CW'(s_len_i) + CW'(1);
  assign first_beats  = (beats_total < CW'(beats_to_bnd)) ? beats_total : CW'(beats_to_bnd);

  assign cur_beats  = BW'(len_q) + BW'(1);
  assign rem_after  = remaining_q - cur_beats;
  assign frag_max   = (CW'(1) << BOUNDARY_BITS) >> size_q;
  assign next_beats = (CW'(rem_after) < frag_max) ? CW'(rem_after) : frag_max;
  // Next fragment starts at the boundary following the current one; wraps.
  assign next_addr  = {addr_q[ADDR_WIDTH-1:BOUNDARY_BITS] + 1'b1, {BOUNDARY_BITS{1'b0}}};

`ifdef SPLIT_BYPASS_EN
  logic crossing;
  assign crossing = beats_total > CW'(beats_to_bnd);
  assign bypass   = ready_en && (state == IDLE) && s_valid_i && !crossing;
`else
  assign bypass = 1'b0;
`endif

  assign down_hs = (state == ISSUE) && m_ready_i;
  assign busy_o  = (state == ISSUE);

  // Ready is held off until the first edge after reset release.
  assign s_ready_o = ready_en &&
                     (((state == IDLE) && !bypass) ||
                      (bypass && m_ready_i) ||
                      ((state == ISSUE) && last_q && m_ready_i));

  // Bypassed bursts complete entirely on the combinational path.
  assign accept = s_valid_i && s_ready_o && !bypass;

  always_comb begin
    state_next  = state;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    id_d        = id_q;
    last_d      = last_q;
    remaining_d = remaining_q;

    if (down_hs) begin
      remaining_d = rem_after;
      if (!last_q) begin
        addr_d = next_addr;
        len_d  = LEN_WIDTH'(next_beats - CW'(1));
        last_d = (next_beats == CW'(rem_after));
      end else if (!accept) begin
        state_next = IDLE;
      end
    end

    // Covers both the idle accept and the accept on the final handshake.
    if (accept) begin
      state_next  = ISSUE;
      addr_d      = s_addr_i;
      len_d       = LEN_WIDTH'(first_beats - CW'(1));
      size_d      = s_size_i;
      id_d        = s_id_i;
      last_d      = (first_beats == beats_total);
      remaining_d = BW'(beats_total);
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      id_q        <= '0;
      last_q      <= 1'b0;
      remaining_q <= '0;
      ready_en    <= 1'b0;
    end else begin
      state       <= state_next;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      id_q        <= id_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
      ready_en    <= 1'b1;
    end
  end

  always_comb begin
    m_valid_o = (state == ISSUE);
    m_addr_o  = addr_q;
    m_len_o   = len_q;
    m_size_o  = size_q;
    m_id_o    = id_q;
    m_last_o  = last_q;
`ifdef SPLIT_BYPASS_EN
    if (bypass) begin
      m_valid_o = 1'b1;
      m_addr_o  = s_addr_i;
      m_len_o   = s_len_i;
      m_size_o  = s_size_i;
      m_id_o    = s_id_i;
      m_last_o  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_splitting_4kb_sequencer.sv
// Testbench for splitting_4kb_sequencer: table of bursts with a scoreboard of
// expected fragments, plus hand-written latency, backpressure and reset cases.
module tb_splitting_4kb_sequencer;

  logic        ACLK_i = 1'b0;
  logic        ARESETn_i;
  logic [31:0] s_addr_i;
  logic [7:0]  s_len_i;
  logic [2:0]  s_size_i;
  logic [3:0]  s_id_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] m_addr_o;
  logic [7:0]  m_len_o;
  logic [2:0]  m_size_o;
  logic [3:0]  m_id_o;
  logic        m_last_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        busy_o;

  always #5 ACLK_i = ~ACLK_i;

  splitting_4kb_sequencer #(
    .ADDR_WIDTH(32),
    .LEN_WIDTH(8),
    .SIZE_WIDTH(3),
    .ID_WIDTH(4),
    .BOUNDARY_BITS(12)
  ) dut (
    .ACLK_i(ACLK_i),
    .ARESETn_i(ARESETn_i),
    .s_addr_i(s_addr_i),
    .s_len_i(s_len_i),
    .s_size_i(s_size_i),
    .s_id_i(s_id_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_addr_o(m_addr_o),
    .m_len_o(m_len_o),
    .m_size_o(m_size_o),
    .m_id_o(m_id_o),
    .m_last_o(m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
    logic        last;
  } frag_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
    int          exp_frags;
    int          exp_first_len;
  } vec_t;

  frag_t sb[$];
  vec_t  vecs[9];

  int checks = 0;
  int failures = 0;
  int total_frags = 0;
  int done_bursts = 0;
  int last_burst_frags = 0;
  int last_burst_first_len = 0;
  int bubbles = 0;
  int cur_frags = 0;
  int cur_first = 0;
  logic in_burst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: walk the burst beat by beat and cut a new fragment
  // whenever a beat lands in a different 4KB page than the previous one.
  task automatic push_model(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [3:0] id);
    logic [31:0] base, baddr, prev;
    frag_t f;
    int cnt;
    base   = (addr >> size) << size;
    f.addr = addr;
    f.size = size;
    f.id   = id;
    f.len  = '0;
    f.last = 1'b0;
    cnt    = 0;
    prev   = base;
    for (int k = 0; k <= int'(len); k++) begin
      baddr = base + (32'(k) << size);
      if (k != 0 && baddr[31:12] != prev[31:12]) begin
        f.len  = 8'(cnt - 1);
        f.last = 1'b0;
        sb.push_back(f);
        f.addr = baddr;
        cnt    = 0;
      end
      cnt++;
      prev = baddr;
    end
    f.len  = 8'(cnt - 1);
    f.last = 1'b1;
    sb.push_back(f);
  endtask

  task automatic send(input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [3:0] id);
    int n;
    @(posedge ACLK_i);
    #1;
    s_addr_i  = addr;
    s_len_i   = len;
    s_size_i  = size;
    s_id_i    = id;
    s_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK_i);
      n++;
    end while (!s_ready_o && n < 100);
    chk("accept_timeout", {31'd0, s_ready_o}, 32'd1);
    @(posedge ACLK_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int target);
    int n;
    n = 0;
    while (done_bursts < target && n < 400) begin
      @(negedge ACLK_i);
      n++;
    end
    chk("drain_timeout", {31'd0, done_bursts >= target}, 32'd1);
  endtask

  // Output monitor and scoreboard.
  always @(negedge ACLK_i) begin
    frag_t e;
    if (!ARESETn_i) begin
      in_burst  = 1'b0;
      cur_frags = 0;
    end else begin
      if (in_burst && !m_valid_o) bubbles++;
      if (m_valid_o && m_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frag actual addr=0x%0h len=%0d expected none", m_addr_o, m_len_o);
        end else begin
          e = sb.pop_front();
          if (m_addr_o !== e.addr || m_len_o !== e.len || m_size_o !== e.size ||
              m_id_o !== e.id || m_last_o !== e.last) begin
            failures++;
            $display("FAIL frag actual addr=0x%0h len=%0d size=%0d id=%0d last=%0b expected addr=0x%0h len=%0d size=%0d id=%0d last=%0b",
                     m_addr_o, m_len_o, m_size_o, m_id_o, m_last_o,
                     e.addr, e.len, e.size, e.id, e.last);
          end
        end
        if (cur_frags == 0) cur_first = int'(m_len_o);
        cur_frags++;
        total_frags++;
        if (m_last_o) begin
          last_burst_frags     = cur_frags;
          last_burst_first_len = cur_first;
          done_bursts++;
          cur_frags = 0;
          in_burst  = 1'b0;
        end else begin
          in_burst = 1'b1;
        end
      end
    end
  end

  initial begin
    int exp_bursts;
    int base;
    int snap;
    int n;

    vecs[0] = '{32'h0000_0FF0, 8'd7,   3'd2, 4'd1, 2, 3};
    vecs[1] = '{32'h0000_0800, 8'd255, 3'd7, 4'd2, 9, 15};
    vecs[2] = '{32'h0000_0000, 8'd255, 3'd4, 4'd3, 1, 255};
    vecs[3] = '{32'h0000_1000, 8'd0,   3'd0, 4'd4, 1, 0};
    vecs[4] = '{32'h0000_0F00, 8'd63,  3'd2, 4'd5, 1, 63};
    vecs[5] = '{32'h0000_0FFF, 8'd1,   3'd0, 4'd6, 2, 0};
    vecs[6] = '{32'hFFFF_FFF8, 8'd3,   3'd2, 4'd7, 2, 1};
    vecs[7] = '{32'h0000_0FF3, 8'd3,   3'd2, 4'd8, 1, 3};
    vecs[8] = '{32'h0000_0F80, 8'd255, 3'd0, 4'd9, 2, 127};

    ARESETn_i = 1'b0;
    s_addr_i  = '0;
    s_len_i   = '0;
    s_size_i  = '0;
    s_id_i    = '0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    exp_bursts = 0;

    #2;
    chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready_o}, 32'd0);
    chk("rst_busy",    {31'd0, busy_o},    32'd0);
    chk("rst_m_last",  {31'd0, m_last_o},  32'd0);
    chk("rst_m_addr",  m_addr_o, 32'd0);
    chk("rst_m_len",   {24'd0, m_len_o}, 32'd0);
    chk("rst_m_id",    {28'd0, m_id_o},  32'd0);

    repeat (3) @(posedge ACLK_i);
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;
    #1;
    chk("release_s_ready_before_edge", {31'd0, s_ready_o}, 32'd0);
    @(posedge ACLK_i);
    #1;
    chk("release_s_ready_after_edge", {31'd0, s_ready_o}, 32'd1);

    // Table of bursts with m_ready_i held high.
    for (int i = 0; i < 9; i++) begin
      push_model(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].id);
      send(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].id);
      exp_bursts++;
      wait_drain(exp_bursts);
      chk($sformatf("vec%0d_frags", i), 32'(last_burst_frags), 32'(vecs[i].exp_frags));
      chk($sformatf("vec%0d_first_len", i), 32'(last_burst_first_len), 32'(vecs[i].exp_first_len));
    end
    chk("no_bubbles", 32'(bubbles), 32'd0);
    chk("idle_after_table", {31'd0, busy_o}, 32'd0);

    // Latency of a non-crossing 4KB burst.
    push_model(32'h0000_0000, 8'd255, 3'd4, 4'hA);
    @(posedge ACLK_i);
    #1;
    s_addr_i  = 32'h0000_0000;
    s_len_i   = 8'd255;
    s_size_i  = 3'd4;
    s_id_i    = 4'hA;
    s_valid_i = 1'b1;
    @(negedge ACLK_i);
    chk("lat_s_ready", {31'd0, s_ready_o}, 32'd1);
`ifdef SPLIT_BYPASS_EN
    chk("lat_m_valid_same_cycle", {31'd0, m_valid_o}, 32'd1);
    @(posedge ACLK_i);
    #1;
    s_valid_i = 1'b0;
    chk("lat_bypass_no_state", {31'd0, busy_o}, 32'd0);
`else
    chk("lat_m_valid_same_cycle", {31'd0, m_valid_o}, 32'd0);
    @(posedge ACLK_i);
    #1;
    s_valid_i = 1'b0;
    chk("lat_m_valid_next_cycle", {31'd0, m_valid_o}, 32'd1);
`endif
    exp_bursts++;
    wait_drain(exp_bursts);

    // Backpressure on the second fragment, then final handshake and new
    // accept on the same edge.
    push_model(32'h0000_0FF0, 8'd7, 3'd2, 4'hB);
    send(32'h0000_0FF0, 8'd7, 3'd2, 4'hB);
    exp_bursts++;
    @(posedge ACLK_i);
    #1;
    m_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK_i);
      chk("bp_addr",    m_addr_o, 32'h0000_1000);
      chk("bp_len",     {24'd0, m_len_o}, 32'd3);
      chk("bp_last",    {31'd0, m_last_o}, 32'd1);
      chk("bp_valid",   {31'd0, m_valid_o}, 32'd1);
      chk("bp_s_ready", {31'd0, s_ready_o}, 32'd0);
    end
    push_model(32'h0000_2000, 8'd0, 3'd2, 4'hC);
    @(posedge ACLK_i);
    #1;
    s_addr_i  = 32'h0000_2000;
    s_len_i   = 8'd0;
    s_size_i  = 3'd2;
    s_id_i    = 4'hC;
    s_valid_i = 1'b1;
    m_ready_i = 1'b1;
    @(negedge ACLK_i);
    chk("b2b_s_ready", {31'd0, s_ready_o}, 32'd1);
    @(posedge ACLK_i);
    #1;
    s_valid_i = 1'b0;
    chk("b2b_new_addr", m_addr_o, 32'h0000_2000);
    chk("b2b_busy",     {31'd0, busy_o}, 32'd1);
    chk("b2b_valid",    {31'd0, m_valid_o}, 32'd1);
    exp_bursts++;
    wait_drain(exp_bursts);

    // Reset in the middle of the nine-fragment burst.
    push_model(32'h0000_0800, 8'd255, 3'd7, 4'hD);
    base = total_frags;
    send(32'h0000_0800, 8'd255, 3'd7, 4'hD);
    n = 0;
    while (total_frags < base + 3 && n < 100) begin
      @(posedge ACLK_i);
      #1;
      n++;
    end
    chk("mid_frags_before_reset", 32'(total_frags - base), 32'd3);
    #1;
    ARESETn_i = 1'b0;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("mid_rst_busy",    {31'd0, busy_o},    32'd0);
    chk("mid_rst_s_ready", {31'd0, s_ready_o}, 32'd0);
    chk("mid_rst_m_addr",  m_addr_o, 32'd0);
    chk("mid_rst_m_last",  {31'd0, m_last_o}, 32'd0);
    sb.delete();
    snap = total_frags;
    repeat (2) @(posedge ACLK_i);
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;
    #1;
    chk("mid_release_s_ready_before_edge", {31'd0, s_ready_o}, 32'd0);
    @(posedge ACLK_i);
    #1;
    chk("mid_release_s_ready", {31'd0, s_ready_o}, 32'd1);
    repeat (20) @(negedge ACLK_i);
    chk("mid_no_residual", 32'(total_frags), 32'(snap));
    chk("mid_idle_valid",  {31'd0, m_valid_o}, 32'd0);

    // Normal operation after the mid-burst reset.
    push_model(32'h0000_0FF0, 8'd7, 3'd2, 4'hE);
    send(32'h0000_0FF0, 8'd7, 3'd2, 4'hE);
    exp_bursts++;
    wait_drain(exp_bursts);
    chk("post_rst_frags", 32'(last_burst_frags), 32'd2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/splitting_4kb_sequencer.md
SPLITTING_4KB_SEQUENCER -- requirements
Module: splitting_4kb_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 32, address width.
- LEN_WIDTH, 8, AxLEN width.
- SIZE_WIDTH, 3, AxSIZE width.
- ID_WIDTH, 4, AxID width.
- BOUNDARY_BITS, 12, log2 of the boundary in bytes; 12 gives 4KB.
REQ-002 Ports, one per line: name, direction, width, meaning.
- ACLK_i, in, 1, clock.
- ARESETn_i, in, 1, reset; one clock, asynchronous, active-low.
- s_addr_i, in, ADDR_WIDTH, upstream burst start address.
- s_len_i, in, LEN_WIDTH, upstream AxLEN (beats-1).
- s_size_i, in, SIZE_WIDTH, upstream AxSIZE.
- s_id_i, in, ID_WIDTH, upstream AxID.
- s_valid_i, in, 1, upstream valid.
- s_ready_o, out, 1, upstream ready.
- m_addr_o, out, ADDR_WIDTH, fragment address.
- m_len_o, out, LEN_WIDTH, fragment AxLEN.
- m_size_o, out, SIZE_WIDTH, fragment AxSIZE, equal to the upstream size.
- m_id_o, out, ID_WIDTH, fragment AxID, equal to the upstream ID.
- m_last_o, out, 1, marks the final fragment of the burst.
- m_valid_o, out, 1, downstream valid.
- m_ready_i, in, 1, downstream ready.
- busy_o, out, 1, high while the FSM is in ISSUE.

Function
REQ-003 The block SHALL split INCR bursts only; the caller guarantees 2^s_size_i <= 2^BOUNDARY_BITS.
REQ-004 The upstream handshake SHALL complete on s_valid_i&&s_ready_o.
REQ-005 The downstream handshake SHALL complete on m_valid_o&&m_ready_i.
REQ-006 Once m_valid_o is high, the m_* payload SHALL hold stable until the downstream handshake completes.
REQ-007 On accept, the block SHALL compute:
- beats_total = s_len_i+1, at LEN_WIDTH+1 bits;
- off = s_addr_i[BOUNDARY_BITS-1:0] with bits below size cleared;
- beats_to_bnd = (2^BOUNDARY_BITS - off) >> size, at BOUNDARY_BITS+1 bits.
REQ-008 Fragment 0 SHALL carry addr = s_addr_i (unaligned start preserved) and len = min(beats_total, beats_to_bnd)-1.
REQ-009 Each later fragment SHALL carry addr = previous boundary + 2^BOUNDARY_BITS, with low BOUNDARY_BITS bits zero, and len = min(remaining, 2^(BOUNDARY_BITS-size))-1.
REQ-010 The remaining beat count SHALL decrement by the issued fragment length after each downstream handshake.
REQ-011 m_last_o SHALL be high exactly when the issued fragment's beat count equals the remaining beat count.
REQ-012 The FSM SHALL have two states, IDLE and ISSUE.
REQ-013 IDLE -> ISSUE on accept; fragment 0 is registered, and m_valid_o rises the next cycle (1-cycle latency).
REQ-014 In ISSUE, a handshake with m_last_o=0 SHALL load the next fragment in the same edge, with m_valid_o staying high and no bubble.
REQ-015 In ISSUE, a handshake with m_last_o=1 SHALL either go to IDLE, or accept a new burst in the same edge when s_valid_i=1.
REQ-016 s_ready_o SHALL be high in IDLE, or in ISSUE when m_last_o&&m_ready_i.
REQ-017 A burst that does not cross the boundary SHALL produce one fragment with m_last_o=1 and the original addr and len.
REQ-018 An address exactly on a boundary SHALL NOT be treated as crossing.
REQ-019 An end address exactly at the next boundary SHALL NOT be treated as crossing.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH with no error flag.

Reset
REQ-021 Asserting ARESETn_i low SHALL immediately force:
- state = IDLE;
- m_valid_o = 0, m_last_o = 0, busy_o = 0;
- m_addr_o, m_len_o, m_size_o, m_id_o = 0;
- remaining beat count = 0.
REQ-022 While ARESETn_i is low, s_ready_o SHALL be 0.
REQ-023 s_ready_o SHALL rise on the first clock edge after ARESETn_i is released.
REQ-024 Reset mid-burst SHALL discard all outstanding fragments.

Configuration
REQ-025 Macro SPLIT_BYPASS_EN SHALL control the bypass path.
REQ-026 With SPLIT_BYPASS_EN defined, in IDLE with a non-crossing s_valid_i burst:
- m_* and m_valid_o are driven combinationally from s_*, with m_last_o=1;
- s_ready_o = m_ready_i;
- the state does not change (0-cycle latency).
REQ-027 With SPLIT_BYPASS_EN defined, crossing bursts SHALL behave as in REQ-013 to REQ-015.
REQ-028 Without SPLIT_BYPASS_EN, all bursts SHALL take the registered path, and the m_* outputs are flop-driven only.

Verification
REQ-029 Single crossing: addr 0x0000_0FF0, len 7, size 2 -> two fragments:
- {0x0FF0, len 3, last 0};
- {0x1000, len 3, last 1}.
REQ-030 Multi-crossing: addr 0x0000_0800, len 255, size 7 -> nine fragments, with m_ready_i held high and no bubbles:
- {0x0800, len 15};
- seven of {0x1000..0x7000 step 0x1000, len 31};
- {0x8000, len 15, last 1}.
REQ-031 Non-crossing: addr 0x0000_0000, len 255, size 4 (exactly 4KB) -> one fragment {0x0000, len 255, last 1}.
- Registered path: m_valid_o asserts 1 cycle after accept.
- With SPLIT_BYPASS_EN: m_valid_o asserts in the same cycle.
REQ-032 Backpressure: hold m_ready_i=0 for 5 cycles during fragment 1 of REQ-029 -> payload stable and s_ready_o=0 throughout.
- Release m_ready_i with a new s_valid_i pending -> last handshake and new accept occur on the same edge.
REQ-033 Reset mid-burst: drop ARESETn_i after fragment 2 of REQ-030 -> m_valid_o=0 immediately.
- After release, s_ready_o=1 and no residual fragments are issued.
